// File: rtl/tile_origin_seq_if.sv
// Tile origin stream bundle.
// The sequencer drives the beat (out_valid, tile_idx, org_x, org_y, key, out_last) and the
// status flags (busy, done); the consumer drives start, abort and out_ready.
//   master : sequencer side
//   slave  : consumer / controller side
interface tile_origin_seq_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned ORG_W = 12,
  parameter int unsigned KEY_W = 11
);
  logic             start;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] tile_idx;
  logic [ORG_W-1:0] org_x;
  logic [ORG_W-1:0] org_y;
  logic [KEY_W-1:0] key;
  logic             out_last;
  logic             busy;
  logic             done;

  modport master (
    input  start, abort, out_ready,
    output out_valid, tile_idx, org_x, org_y, key, out_last, busy, done
  );

  modport slave (
    output start, abort, out_ready,
    input  out_valid, tile_idx, org_x, org_y, key, out_last, busy, done
  );
endinterface

// File: rtl/tile_origin_seq.sv
// Tile origin sequencer: sweeps a GRID_X x GRID_Y tiling in row-major order and emits one
// valid/ready beat per tile with its linear index, pixel origin and packed row/col key.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : tile_origin_seq_if.master (start/abort/out_ready in; beat, busy, done out)
// All origins and keys are built with accumulators so no multipliers are inferred.
module tile_origin_seq #(
  parameter int unsigned GRID_X    = 3,
  parameter int unsigned GRID_Y    = 3,
  parameter int unsigned STRIDE_X  = 640,
  parameter int unsigned STRIDE_Y  = 640,
  parameter int unsigned KEY_PITCH = 640,
  parameter int unsigned ORG_W     = 12,
  parameter int unsigned KEY_W     = 11,
  parameter int unsigned IDX_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  tile_origin_seq_if.master  bus
);

  localparam int unsigned COL_W = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int unsigned ROW_W = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;

  localparam logic [ORG_W-1:0] StepX = ORG_W'(STRIDE_X);
  localparam logic [ORG_W-1:0] StepY = ORG_W'(STRIDE_Y);
  localparam logic [KEY_W-1:0] Pitch = KEY_W'(KEY_PITCH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ORG_W-1:0] ox_q, ox_d;
  logic [ORG_W-1:0] oy_q, oy_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] row_base_q, row_base_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic run;
  logic col_end;
  logic last_tile;
  logic hs;

  assign run       = (state_q == StRun);
  assign col_end   = (col_q == COL_W'(GRID_X - 1));
  assign last_tile = col_end && (row_q == ROW_W'(GRID_Y - 1));
  assign hs        = run && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort beats a simultaneous final handshake so no done is raised.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (hs && last_tile) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Tile counters and origin accumulators
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    key_d      = key_q;
    row_base_d = row_base_q;
    idx_d      = idx_q;
    if (run && (state_d != StRun)) begin
      // Leaving the sweep (finished or aborted): park everything at the first tile.
      col_d      = '0;
      row_d      = '0;
      ox_d       = '0;
      oy_d       = '0;
      key_d      = '0;
      row_base_d = '0;
      idx_d      = '0;
    end else if (hs) begin
      idx_d = idx_q + IDX_W'(1);
      if (col_end) begin
        col_d      = '0;
        row_d      = row_q + ROW_W'(1);
        ox_d       = '0;
        oy_d       = oy_q + StepY;
        row_base_d = row_base_q + Pitch;
        key_d      = row_base_q + Pitch;
      end else begin
        col_d = col_q + COL_W'(1);
        ox_d  = ox_q + StepX;
        key_d = key_q + KEY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      key_q      <= '0;
      row_base_q <= '0;
      idx_q      <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      key_q      <= key_d;
      row_base_q <= row_base_d;
      idx_q      <= idx_d;
    end
  end

  // Outputs: beat fields are forced to zero whenever no beat is presented.
  always_comb begin
    bus.out_valid = run;
    bus.busy      = run;
    bus.done      = (state_q == StDone);
    bus.out_last  = run && last_tile;
    bus.tile_idx  = run ? idx_q : '0;
    bus.org_x     = run ? ox_q  : '0;
    bus.org_y     = run ? oy_q  : '0;
    bus.key       = run ? key_q : '0;
  end

endmodule

// File: tb/tb_tile_origin_seq.sv
module tb_tile_origin_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Three sequencers side by side: default 3x3, 4x2 with custom strides, and 1x1.
  logic [2:0] st  = '0;
  logic [2:0] rdy = '0;
  logic [2:0] ab  = '0;

  tile_origin_seq_if #(.IDX_W(4), .ORG_W(12), .KEY_W(11)) if_a ();
  tile_origin_seq_if #(.IDX_W(4), .ORG_W(12), .KEY_W(12)) if_b ();
  tile_origin_seq_if #(.IDX_W(4), .ORG_W(12), .KEY_W(11)) if_c ();

  tile_origin_seq dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

  tile_origin_seq #(
    .GRID_X(4), .GRID_Y(2), .STRIDE_X(512), .STRIDE_Y(384), .KEY_PITCH(1024), .KEY_W(12)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

  tile_origin_seq #(.GRID_X(1), .GRID_Y(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

  assign if_a.start = st[0];  assign if_a.out_ready = rdy[0];  assign if_a.abort = ab[0];
  assign if_b.start = st[1];  assign if_b.out_ready = rdy[1];  assign if_b.abort = ab[1];
  assign if_c.start = st[2];  assign if_c.out_ready = rdy[2];  assign if_c.abort = ab[2];

  // Packed view: {valid, last, busy, done, idx, org_x, org_y, key}, fields padded to 12 bits.
  logic [51:0] act [3];
  assign act[0] = {if_a.out_valid, if_a.out_last, if_a.busy, if_a.done, 12'(if_a.tile_idx),
                   12'(if_a.org_x), 12'(if_a.org_y), 12'(if_a.key)};
  assign act[1] = {if_b.out_valid, if_b.out_last, if_b.busy, if_b.done, 12'(if_b.tile_idx),
                   12'(if_b.org_x), 12'(if_b.org_y), 12'(if_b.key)};
  assign act[2] = {if_c.out_valid, if_c.out_last, if_c.busy, if_c.done, 12'(if_c.tile_idx),
                   12'(if_c.org_x), 12'(if_c.org_y), 12'(if_c.key)};

  int gx [3] = '{3, 4, 1};
  int gy [3] = '{3, 2, 1};
  int sx [3] = '{640, 512, 640};
  int sy [3] = '{640, 384, 640};
  int kp [3] = '{640, 1024, 640};

  // Reference model: 0 idle, 1 sweeping (beat number m_n), 2 done pulse.
  int m_mode [3] = '{0, 0, 0};
  int m_n    [3] = '{0, 0, 0};
  int hs_cnt   [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  logic [51:0] snap [3];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [51:0] pk(logic v, logic l, logic dn, int idx, int ox, int oy, int k);
    return {v, l, v, dn, 12'(idx), 12'(ox), 12'(oy), 12'(k)};
  endfunction

  function automatic logic [51:0] model_out(int d);
    int col, row;
    if (m_mode[d] == 1) begin
      col = m_n[d] % gx[d];
      row = m_n[d] / gx[d];
      return pk(1'b1, (m_n[d] == gx[d] * gy[d] - 1), 1'b0, m_n[d], col * sx[d], row * sy[d],
                row * kp[d] + col);
    end
    if (m_mode[d] == 2) return pk(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    return '0;
  endfunction

  task automatic chk(input string name, input int d, input logic [51:0] a, input logic [51:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d: got vlbd=%b idx=%0d ox=%0d oy=%0d key=%0d, want vlbd=%b idx=%0d ox=%0d oy=%0d key=%0d",
               name, d, a[51:48], a[47:36], a[35:24], a[23:12], a[11:0],
               e[51:48], e[47:36], e[35:24], e[23:12], e[11:0]);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // One clock: drive, compare all DUTs to the model mid-cycle, then advance the model.
  task automatic cycle(input logic [2:0] s, input logic [2:0] r, input logic [2:0] a,
                       input logic rs);
    st = s; rdy = r; ab = a; rst = rs;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      snap[d] = act[d];
      chk("model", d, act[d], model_out(d));
      if (act[d][48]) done_cnt[d]++;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rs) begin
        m_mode[d] = 0; m_n[d] = 0;
      end else begin
        case (m_mode[d])
          0: if (s[d]) begin m_mode[d] = 1; m_n[d] = 0; end
          1: begin
            if (r[d]) hs_cnt[d]++;
            if (a[d]) m_mode[d] = 0;
            else if (r[d]) begin
              if (m_n[d] == gx[d] * gy[d] - 1) m_mode[d] = 2;
              else m_n[d]++;
            end
          end
          default: m_mode[d] = 0;
        endcase
      end
    end
    #1;
  endtask

  typedef struct {
    logic st; logic rdy; logic v; logic l; logic dn; int idx; int ox; int oy; int key;
  } vec_t;
  vec_t tab [12];

  initial begin
    tab[0]  = '{1, 1, 0, 0, 0, 0, 0,    0,    0};
    tab[1]  = '{0, 1, 1, 0, 0, 0, 0,    0,    0};
    tab[2]  = '{0, 1, 1, 0, 0, 1, 640,  0,    1};
    tab[3]  = '{0, 1, 1, 0, 0, 2, 1280, 0,    2};
    tab[4]  = '{0, 1, 1, 0, 0, 3, 0,    640,  640};
    tab[5]  = '{0, 1, 1, 0, 0, 4, 640,  640,  641};
    tab[6]  = '{0, 1, 1, 0, 0, 5, 1280, 640,  642};
    tab[7]  = '{0, 1, 1, 0, 0, 6, 0,    1280, 1280};
    tab[8]  = '{0, 1, 1, 0, 0, 7, 640,  1280, 1281};
    tab[9]  = '{0, 1, 1, 1, 0, 8, 1280, 1280, 1282};
    tab[10] = '{0, 1, 0, 0, 1, 0, 0,    0,    0};
    tab[11] = '{0, 1, 0, 0, 0, 0, 0,    0,    0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle(3'b000, 3'b000, 3'b000, 1'b1);
    for (int d = 0; d < 3; d++) chk("reset", d, snap[d], '0);

    // Full default sweep from the vector table
    for (int i = 0; i < 12; i++) begin
      cycle({2'b00, tab[i].st}, {2'b00, tab[i].rdy}, 3'b000, 1'b0);
      chk($sformatf("tab%0d", i), 0, snap[0],
          pk(tab[i].v, tab[i].l, tab[i].dn, tab[i].idx, tab[i].ox, tab[i].oy, tab[i].key));
    end

    // Stall three cycles on key 641
    hs_cnt[0] = 0;
    cycle(3'b001, 3'b001, 3'b000, 1'b0);
    repeat (4) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 3'b000, 3'b000, 1'b0);
      chk("stall_hold", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 4, 640, 640, 641));
    end
    cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk("stall_resume", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 4, 640, 640, 641));
    cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk("after_stall", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 5, 1280, 640, 642));
    repeat (4) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 3'b000, 1'b0);
    chk_int("stall_handshakes", hs_cnt[0], 9);

    // Abort on beat key 640, then a fresh sweep restarts at key 0
    done_cnt[0] = 0;
    cycle(3'b001, 3'b001, 3'b000, 1'b0);
    repeat (3) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    cycle(3'b000, 3'b001, 3'b001, 1'b0);
    chk("abort_beat", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 3, 0, 640, 640));
    cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk("abort_idle", 0, snap[0], '0);
    repeat (3) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk_int("abort_no_done", done_cnt[0], 0);
    cycle(3'b001, 3'b000, 3'b000, 1'b0);
    cycle(3'b000, 3'b000, 3'b000, 1'b0);
    chk("restart_key0", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 0, 0, 0, 0));
    cycle(3'b000, 3'b000, 3'b001, 1'b0);
    cycle(3'b000, 3'b000, 3'b000, 1'b0);

    // start held high through the whole sweep: one sweep, one done
    hs_cnt[0] = 0; done_cnt[0] = 0;
    repeat (11) cycle(3'b001, 3'b001, 3'b000, 1'b0);
    repeat (2) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk_int("start_spam_hs", hs_cnt[0], 9);
    chk_int("start_spam_done", done_cnt[0], 1);

    // Reset on the fifth beat
    cycle(3'b001, 3'b001, 3'b000, 1'b0);
    repeat (4) cycle(3'b000, 3'b001, 3'b000, 1'b0);
    cycle(3'b000, 3'b001, 3'b000, 1'b1);
    chk("rst_beat5", 0, snap[0], pk(1'b1, 1'b0, 1'b0, 4, 640, 640, 641));
    cycle(3'b000, 3'b001, 3'b000, 1'b0);
    chk("rst_idle", 0, snap[0], '0);

    // 4x2 grid with custom strides
    cycle(3'b010, 3'b010, 3'b000, 1'b0);
    repeat (6) cycle(3'b000, 3'b010, 3'b000, 1'b0);
    chk("g42_beat5", 1, snap[1], pk(1'b1, 1'b0, 1'b0, 5, 512, 384, 1025));
    cycle(3'b000, 3'b010, 3'b000, 1'b0);
    cycle(3'b000, 3'b010, 3'b000, 1'b0);
    chk("g42_last", 1, snap[1], pk(1'b1, 1'b1, 1'b0, 7, 1536, 384, 1027));
    cycle(3'b000, 3'b010, 3'b000, 1'b0);
    chk("g42_done", 1, snap[1], pk(1'b0, 1'b0, 1'b1, 0, 0, 0, 0));

    // 1x1 grid: single last beat; abort with the last handshake suppresses done
    cycle(3'b100, 3'b100, 3'b000, 1'b0);
    cycle(3'b000, 3'b100, 3'b000, 1'b0);
    chk("g11_beat", 2, snap[2], pk(1'b1, 1'b1, 1'b0, 0, 0, 0, 0));
    cycle(3'b000, 3'b100, 3'b000, 1'b0);
    chk("g11_done", 2, snap[2], pk(1'b0, 1'b0, 1'b1, 0, 0, 0, 0));
    cycle(3'b100, 3'b100, 3'b000, 1'b0);
    cycle(3'b000, 3'b100, 3'b100, 1'b0);
    chk("g11_abort_beat", 2, snap[2], pk(1'b1, 1'b1, 1'b0, 0, 0, 0, 0));
    cycle(3'b000, 3'b100, 3'b000, 1'b0);
    chk("g11_abort_nodone", 2, snap[2], '0);

    // Randomized traffic on all three grids against the model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rs_, rr, ra;
      for (int d = 0; d < 3; d++) begin
        rs_[d] = ($urandom % 5) == 0;
        rr[d]  = ($urandom % 4) != 0;
        ra[d]  = ($urandom % 25) == 0;
      end
      cycle(rs_, rr, ra, ($urandom % 150) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
